// File: rtl/cpi_global_ctrl.sv
// CPI global link controller.
// Runs the connect / disconnect handshake with the fabric, keeps the sticky
// fatal / viral / timeout error flags, and tracks epoch open / commit / reject
// numbering while the link is up.
module cpi_global_ctrl #(
    parameter int EPOCH_W   = 8,
    parameter int NUM_RX_CH = 4,
    parameter int TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 connect_en,
    input  logic                 disconnect_req,
    output logic                 txcon_req,
    input  logic                 rxcon_ack,
    input  logic                 rxdiscon_nack,
    input  logic [NUM_RX_CH-1:0] rx_empty,
    input  logic                 err_fatal_in,
    input  logic                 err_viral_in,
    output logic                 fatal,
    output logic                 viral,
    input  logic                 epoch_open,
    input  logic                 epoch_close_ok,
    input  logic                 epoch_close_fail,
    output logic [EPOCH_W-1:0]   epoch_id,
    output logic [EPOCH_W-1:0]   epoch_commit,
    output logic [EPOCH_W-1:0]   epoch_reject,
    output logic                 link_up,
    output logic [2:0]           state,
    output logic                 timeout_err
);

    typedef enum logic [2:0] {
        ST_DISC      = 3'd0,
        ST_CONN_REQ  = 3'd1,
        ST_CONNECTED = 3'd2,
        ST_DISC_REQ  = 3'd3,
        ST_ERROR     = 3'd4
    } state_t;

    // Last count value before a handshake wait is declared stuck.
    localparam logic [15:0] WAIT_MAX = 16'(TIMEOUT - 1);

    state_t      state_q;
    state_t      next_state;
    logic [15:0] wait_cnt;
    logic        wait_done;
    logic        timeout_hit;
    logic        enter_error;
    logic        fatal_set;
    logic        epoch_active;
    logic        leave_bad;
    logic        close_ok;
    logic        close_fail;
    logic        abort;
    logic        closing;
    logic        open_ok;

    assign wait_done = (wait_cnt == WAIT_MAX);
    assign state     = state_q;

    // Next-state decode for the link handshake.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (which would infer a latch).
        next_state  = state_q;
        timeout_hit = 1'b0;
        case (state_q)
            ST_DISC: begin
                // A stale ack from the fabric blocks a new request.
                if (connect_en && !rxcon_ack) next_state = ST_CONN_REQ;
            end
            ST_CONN_REQ: begin
                if (!connect_en) begin
                    next_state = ST_DISC;
                end else if (rxcon_ack) begin
                    next_state = ST_CONNECTED;
                end else if (wait_done) begin
                    next_state  = ST_ERROR;
                    timeout_hit = 1'b1;
                end
            end
            ST_CONNECTED: begin
                // Fabric dropping ack under us is fatal and beats a local disconnect.
                if (!rxcon_ack) begin
                    next_state = ST_ERROR;
                end else if (disconnect_req || !connect_en) begin
                    next_state = ST_DISC_REQ;
                end
            end
            ST_DISC_REQ: begin
                if (rxdiscon_nack) begin
                    next_state = ST_CONNECTED;
                end else if (!rxcon_ack && (&rx_empty)) begin
                    next_state = ST_DISC;
                end else if (wait_done) begin
                    next_state  = ST_ERROR;
                    timeout_hit = 1'b1;
                end
            end
            ST_ERROR: next_state = ST_ERROR;
            default:  next_state = ST_ERROR;
        endcase
    end

    assign enter_error = (next_state == ST_ERROR) && (state_q != ST_ERROR);
    assign fatal_set   = err_fatal_in || enter_error;

    // State register, handshake wait counter and registered link outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_DISC;
            wait_cnt  <= '0;
            txcon_req <= 1'b0;
            link_up   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            state_q   <= next_state;
            txcon_req <= (next_state == ST_CONN_REQ) || (next_state == ST_CONNECTED);
            link_up   <= (next_state == ST_CONNECTED);
            if (next_state != state_q) begin
                wait_cnt <= '0;
            end else if ((state_q == ST_CONN_REQ) || (state_q == ST_DISC_REQ)) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
        end
    end

    // Sticky error flags; viral follows every new fatal event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fatal       <= 1'b0;
            viral       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (fatal_set)                  fatal       <= 1'b1;
            if (fatal_set || err_viral_in)  viral       <= 1'b1;
            if (timeout_hit)                timeout_err <= 1'b1;
        end
    end

    // Epoch bookkeeping: a close retires the current number, an open may reuse the same cycle.
    assign leave_bad  = (state_q == ST_CONNECTED) && (next_state != ST_CONNECTED)
                        && (next_state != ST_DISC_REQ);
    assign close_fail = epoch_active && epoch_close_fail;
    assign close_ok   = epoch_active && epoch_close_ok && !epoch_close_fail;
    assign abort      = epoch_active && leave_bad;
    assign closing    = close_fail || close_ok || abort;
    assign open_ok    = epoch_open && link_up && !leave_bad && (!epoch_active || closing);

    // Epoch number, commit / reject capture and open flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            epoch_id     <= '0;
            epoch_commit <= '0;
            epoch_reject <= '0;
            epoch_active <= 1'b0;
        end else begin
            if (close_fail || abort) begin
                epoch_reject <= epoch_id;
            end else if (close_ok) begin
                epoch_commit <= epoch_id;
            end
            if (open_ok) begin
                epoch_id     <= epoch_id + 1'b1;
                epoch_active <= 1'b1;
            end else if (closing) begin
                epoch_active <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cpi_global_ctrl.sv
// Directed bench for cpi_global_ctrl with TIMEOUT=16, EPOCH_W=2, four RX channels.
module tb_cpi_global_ctrl;

    localparam int EW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          connect_en, disconnect_req, rxcon_ack, rxdiscon_nack;
    logic [3:0]    rx_empty;
    logic          err_fatal_in, err_viral_in;
    logic          epoch_open, epoch_close_ok, epoch_close_fail;
    logic          txcon_req, fatal, viral, link_up, timeout_err;
    logic [EW-1:0] epoch_id, epoch_commit, epoch_reject;
    logic [2:0]    state;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    cpi_global_ctrl #(.EPOCH_W(EW), .NUM_RX_CH(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .connect_en(connect_en), .disconnect_req(disconnect_req),
        .txcon_req(txcon_req), .rxcon_ack(rxcon_ack), .rxdiscon_nack(rxdiscon_nack),
        .rx_empty(rx_empty), .err_fatal_in(err_fatal_in), .err_viral_in(err_viral_in),
        .fatal(fatal), .viral(viral),
        .epoch_open(epoch_open), .epoch_close_ok(epoch_close_ok),
        .epoch_close_fail(epoch_close_fail),
        .epoch_id(epoch_id), .epoch_commit(epoch_commit), .epoch_reject(epoch_reject),
        .link_up(link_up), .state(state), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle 1ns past it before checking or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".state"},   32'(state), 32'd0);
        check({tag, ".txcon"},   32'(txcon_req), 32'd0);
        check({tag, ".link"},    32'(link_up), 32'd0);
        check({tag, ".fatal"},   32'(fatal), 32'd0);
        check({tag, ".viral"},   32'(viral), 32'd0);
        check({tag, ".tmo"},     32'(timeout_err), 32'd0);
        check({tag, ".id"},      32'(epoch_id), 32'd0);
        check({tag, ".commit"},  32'(epoch_commit), 32'd0);
        check({tag, ".reject"},  32'(epoch_reject), 32'd0);
    endtask

    task automatic pulse_epoch(input logic o, input logic ok, input logic fl);
        epoch_open = o; epoch_close_ok = ok; epoch_close_fail = fl;
        tick();
        epoch_open = 1'b0; epoch_close_ok = 1'b0; epoch_close_fail = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        connect_en = 0; disconnect_req = 0; rxcon_ack = 0; rxdiscon_nack = 0;
        rx_empty = 4'b1111; err_fatal_in = 0; err_viral_in = 0;
        epoch_open = 0; epoch_close_ok = 0; epoch_close_fail = 0;
        #3;
        check_reset("por");
        tick();
        rst_n = 1'b1;

        // Connect: ack arrives after three cycles of request.
        connect_en = 1'b1;
        tick();
        check("conn.state", 32'(state), 32'd1);
        check("conn.txcon", 32'(txcon_req), 32'd1);
        check("conn.link0", 32'(link_up), 32'd0);
        tick(); tick();
        check("conn.wait", 32'(state), 32'd1);
        rxcon_ack = 1'b1;
        tick();
        check("conn.up.state", 32'(state), 32'd2);
        check("conn.up.link",  32'(link_up), 32'd1);

        // Five open / close_ok pairs with a 2-bit epoch: commits 1,2,3,0,1.
        for (int i = 0; i < 5; i++) begin
            pulse_epoch(1'b1, 1'b0, 1'b0);
            pulse_epoch(1'b0, 1'b1, 1'b0);
            check($sformatf("ep.commit%0d", i), 32'(epoch_commit), 32'((i + 1) % 4));
        end
        // Simultaneous ok+fail counts as fail.
        pulse_epoch(1'b1, 1'b0, 1'b0);
        check("ep.id2", 32'(epoch_id), 32'd2);
        pulse_epoch(1'b0, 1'b1, 1'b1);
        check("ep.okfail.rej", 32'(epoch_reject), 32'd2);
        check("ep.okfail.com", 32'(epoch_commit), 32'd1);
        // Open while already open is ignored.
        pulse_epoch(1'b1, 1'b0, 1'b0);
        pulse_epoch(1'b1, 1'b0, 1'b0);
        check("ep.dblopen", 32'(epoch_id), 32'd3);
        // Close + open in one cycle: commit 3, reopen as 0 (wrap).
        pulse_epoch(1'b1, 1'b1, 1'b0);
        check("ep.cl_op.com", 32'(epoch_commit), 32'd3);
        check("ep.cl_op.id",  32'(epoch_id), 32'd0);
        pulse_epoch(1'b0, 1'b0, 1'b1);
        check("ep.fail.rej", 32'(epoch_reject), 32'd0);
        // Close with nothing open is ignored.
        pulse_epoch(1'b0, 1'b1, 1'b0);
        check("ep.noopen", 32'(epoch_commit), 32'd3);

        // Disconnect refused by the fabric.
        disconnect_req = 1'b1;
        tick();
        disconnect_req = 1'b0;
        check("nack.state3", 32'(state), 32'd3);
        check("nack.txcon0", 32'(txcon_req), 32'd0);
        rxdiscon_nack = 1'b1;
        tick();
        rxdiscon_nack = 1'b0;
        check("nack.state2", 32'(state), 32'd2);
        check("nack.txcon1", 32'(txcon_req), 32'd1);
        check("nack.fatal",  32'(fatal), 32'd0);

        // Disconnect completes only once every channel is empty.
        disconnect_req = 1'b1;
        tick();
        disconnect_req = 1'b0;
        rxcon_ack = 1'b0;
        rx_empty = 4'b1011;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("drain.hold%0d", i), 32'(state), 32'd3);
        end
        rx_empty = 4'b1111;
        connect_en = 1'b0;
        tick();
        check("drain.disc",  32'(state), 32'd0);
        check("drain.link",  32'(link_up), 32'd0);
        check("drain.txcon", 32'(txcon_req), 32'd0);

        // Fabric drop while connected with an epoch open.
        connect_en = 1'b1;
        tick();
        rxcon_ack = 1'b1;
        tick();
        check("drop.up", 32'(state), 32'd2);
        pulse_epoch(1'b1, 1'b0, 1'b0);
        check("drop.id", 32'(epoch_id), 32'd1);
        rxcon_ack = 1'b0;
        tick();
        check("drop.state", 32'(state), 32'd4);
        check("drop.fatal", 32'(fatal), 32'd1);
        check("drop.viral", 32'(viral), 32'd1);
        check("drop.tmo",   32'(timeout_err), 32'd0);
        check("drop.rej",   32'(epoch_reject), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset("drop.rst");
        tick();
        rst_n = 1'b1;

        // Handshake timeout: ERROR 16 cycles after entering CONN_REQ.
        tick();
        check("tmo.entry", 32'(state), 32'd1);
        for (int i = 0; i < 15; i++) tick();
        check("tmo.last", 32'(state), 32'd1);
        tick();
        check("tmo.state", 32'(state), 32'd4);
        check("tmo.flag",  32'(timeout_err), 32'd1);
        check("tmo.fatal", 32'(fatal), 32'd1);
        check("tmo.viral", 32'(viral), 32'd1);
        check("tmo.txcon", 32'(txcon_req), 32'd0);
        connect_en = 1'b0;
        rxcon_ack = 1'b1;
        tick(); tick(); tick();
        check("tmo.stuck", 32'(state), 32'd4);
        rst_n = 1'b0;
        #1;
        check_reset("tmo.rst");
        tick();
        rst_n = 1'b1;
        rxcon_ack = 1'b0;

        // Local error inputs: viral alone, then fatal drags viral, no state change.
        err_viral_in = 1'b1;
        tick();
        err_viral_in = 1'b0;
        check("err.viral", 32'(viral), 32'd1);
        check("err.nofat", 32'(fatal), 32'd0);
        err_fatal_in = 1'b1;
        tick();
        err_fatal_in = 1'b0;
        check("err.fatal", 32'(fatal), 32'd1);
        check("err.state", 32'(state), 32'd0);

        // Asynchronous reset in DISC_REQ with an epoch open.
        connect_en = 1'b1;
        tick();
        rxcon_ack = 1'b1;
        tick();
        pulse_epoch(1'b1, 1'b0, 1'b0);
        disconnect_req = 1'b1;
        tick();
        disconnect_req = 1'b0;
        check("ar.dreq", 32'(state), 32'd3);
        check("ar.id",   32'(epoch_id), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset("ar.rst");
        connect_en = 1'b0;
        rxcon_ack = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("ar.after", 32'(state), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
